// File: rtl/adc_spi_responder.sv
// Responder model of the 8-channel 12-bit SPI ADC, oversampled on clk_50.
// Returns {4'b0, ch_data[addr]} MSB-first and captures the next address.
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk_50,
   input  logic             rst,
   input  logic             cs_n,
   input  logic             adc_clk,
   input  logic             adc_din,
   input  logic [95:0]      ch_data,
   output logic             adc_dout,
   output logic             active,
   output logic             frame_done,
   output logic [2:0]       last_addr,
   output logic [CNT_W-1:0] frame_count
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
   logic                   cs_dly_q, sclk_dly_q;

   logic cs_s, sclk_s, din_s;
   logic cs_fall, cs_rise, sclk_rise, sclk_fall;

   logic [15:0]      shift_q, shift_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [12:0]      din_sr_q, din_sr_d;
   logic [2:0]       cur_addr_q, cur_addr_d;
   logic [2:0]       last_addr_q, last_addr_d;
   logic             adc_dout_q, adc_dout_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0]  new_addr;
   logic [11:0] cur_data, new_data;

   assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
   assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], adc_clk};
   assign din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], adc_din};

   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign din_s  = din_sync_q[SYNC_STAGES-1];

   assign cs_fall   = cs_dly_q & ~cs_s;
   assign cs_rise   = ~cs_dly_q & cs_s;
   assign sclk_rise = ~sclk_dly_q & sclk_s;
   assign sclk_fall = sclk_dly_q & ~sclk_s;

   // din_sr[j] holds frame bit j+1 when the 16th rising edge arrives
   assign new_addr = din_sr_q[12:10];
   assign cur_data = ch_data[12*int'(cur_addr_q) +: 12];
   assign new_data = ch_data[12*int'(new_addr) +: 12];

   always_ff @(posedge clk_50) begin
      if (rst) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '1;
         din_sync_q  <= '0;
         cs_dly_q    <= 1'b1;
         sclk_dly_q  <= 1'b1;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         din_sync_q  <= din_sync_d;
         cs_dly_q    <= cs_s;
         sclk_dly_q  <= sclk_s;
      end
   end

   always_ff @(posedge clk_50) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (cs_fall) state_d = SHIFT;
         SHIFT: if (cs_rise) state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      din_sr_d    = din_sr_q;
      cur_addr_d  = cur_addr_q;
      last_addr_d = last_addr_q;
      adc_dout_d  = adc_dout_q;
      active_d    = active_q;
      done_d      = 1'b0;
      cnt_d       = cnt_q;
      unique case (state_q)
         IDLE: begin
            adc_dout_d = 1'b0;
            active_d   = 1'b0;
            if (cs_fall) begin
               shift_d   = {4'h0, cur_data};
               bit_cnt_d = 4'd0;
               din_sr_d  = '0;
               active_d  = 1'b1;
            end
         end
         SHIFT: begin
            // chip-select release wins over a coincident sclk edge
            if (cs_rise) begin
               adc_dout_d = 1'b0;
               active_d   = 1'b0;
            end else if (sclk_rise) begin
               din_sr_d = {din_sr_q[11:0], din_s};
               if (bit_cnt_q == 4'd15) begin
                  cur_addr_d  = new_addr;
                  last_addr_d = new_addr;
                  done_d      = 1'b1;
                  cnt_d       = cnt_q + CNT_W'(1);
                  bit_cnt_d   = 4'd0;
                  shift_d     = {4'h0, new_data};
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (sclk_fall) begin
               if (bit_cnt_q == 4'd0) begin
                  adc_dout_d = shift_q[15];
               end else begin
                  shift_d    = {shift_q[14:0], 1'b0};
                  adc_dout_d = shift_q[14];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         din_sr_q    <= '0;
         cur_addr_q  <= '0;
         last_addr_q <= '0;
         adc_dout_q  <= 1'b0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         din_sr_q    <= din_sr_d;
         cur_addr_q  <= cur_addr_d;
         last_addr_q <= last_addr_d;
         adc_dout_q  <= adc_dout_d;
         active_q    <= active_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
      end
   end

   assign adc_dout    = adc_dout_q;
   assign active      = active_q;
   assign frame_done  = done_q;
   assign last_addr   = last_addr_q;
   assign frame_count = cnt_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized SPI initiator bench for adc_spi_responder with an event-level
// reference model checked every cycle.
`timescale 1ns/1ps
module tb_adc_spi_responder;

   localparam int SS  = 2;
   localparam int CW  = 4;
   localparam int LAT = SS + 1;

   localparam int EV_FALL = 0;
   localparam int EV_RISE = 1;
   localparam int EV_DONE = 2;
   localparam int EV_RST  = 3;

   logic          clk_50 = 1'b0;
   logic          rst = 1'b1;
   logic          cs_n = 1'b1;
   logic          adc_clk = 1'b1;
   logic          adc_din = 1'b0;
   logic [95:0]   ch_data = '0;
   logic          adc_dout;
   logic          active;
   logic          frame_done;
   logic [2:0]    last_addr;
   logic [CW-1:0] frame_count;

   adc_spi_responder #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .clk_50      (clk_50),
      .rst         (rst),
      .cs_n        (cs_n),
      .adc_clk     (adc_clk),
      .adc_din     (adc_din),
      .ch_data     (ch_data),
      .adc_dout    (adc_dout),
      .active      (active),
      .frame_done  (frame_done),
      .last_addr   (last_addr),
      .frame_count (frame_count)
   );

   always #10 clk_50 = ~clk_50;

   int n_cmp = 0;
   int n_fail = 0;
   int sample_cnt = 0;
   int pulses = 0;
   int cmp_i;

   int          ev_due[$];
   int          ev_kind[$];
   int          ev_addr[$];
   logic [15:0] rx_q[$];
   logic [15:0] txw[$];
   logic [15:0] got[$];

   bit          m_act = 0;
   bit          m_done = 0;
   int          m_cnt = 0;
   int          m_last = 0;
   int          m_cur = 0;
   logic [15:0] m_word = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] chv(input int n);
      return ch_data[n*12 +: 12];
   endfunction

   task automatic push(input int kind, input int addr, input int lat);
      ev_due.push_back(sample_cnt + lat);
      ev_kind.push_back(kind);
      ev_addr.push_back(addr);
   endtask

   task automatic apply(input int kind, input int addr);
      case (kind)
         EV_FALL: if (!m_act) begin
            m_act  = 1;
            m_word = {4'h0, chv(m_cur)};
         end
         EV_RISE: m_act = 0;
         EV_DONE: if (m_act) begin
            m_done = 1;
            m_cnt  = (m_cnt + 1) % (1 << CW);
            m_last = addr;
            m_cur  = addr;
            if (rx_q.size() == 0) chk("rx_present", 0, 1);
            else chk("rx_word", rx_q.pop_front(), m_word);
            m_word = {4'h0, chv(m_cur)};
         end
         default: begin
            m_act  = 0;
            m_cnt  = 0;
            m_last = 0;
            m_cur  = 0;
            rx_q.delete();
         end
      endcase
   endtask

   initial forever begin
      @(posedge clk_50);
      #5;
      sample_cnt++;
      m_done = 0;
      cmp_i = 0;
      while (cmp_i < ev_due.size()) begin
         if (ev_due[cmp_i] == sample_cnt) begin
            apply(ev_kind[cmp_i], ev_addr[cmp_i]);
            ev_due.delete(cmp_i);
            ev_kind.delete(cmp_i);
            ev_addr.delete(cmp_i);
         end else begin
            cmp_i++;
         end
      end
      chk("frame_done", frame_done, m_done);
      chk("active", active, m_act);
      chk("frame_count", frame_count, m_cnt);
      chk("last_addr", last_addr, m_last);
      if (!m_act) chk("dout_idle", adc_dout, 0);
      if (frame_done === 1'b1) pulses++;
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   // stop_k >= 0 ends the burst at that rising-edge count: either an abort
   // with cs rising together with the next sclk rise, or a reset
   task automatic burst(input int h, input int stop_k, input bit stop_rst,
                        input int chg_at, input int chg_ch,
                        input logic [11:0] chg_val);
      int rises;
      logic [15:0] rxw;
      rises = 0;
      rxw = '0;
      cs_n = 1'b0;
      push(EV_FALL, 0, LAT);
      wait_n(h);
      for (int f = 0; f < txw.size(); f++) begin
         for (int i = 15; i >= 0; i--) begin
            if (rises == stop_k) begin
               if (stop_rst) begin
                  rst  = 1'b1;
                  cs_n = 1'b1;
                  push(EV_RST, 0, 1);
                  push(EV_RISE, 0, LAT);
                  @(posedge clk_50);
                  #6;
                  chk("rst_active", active, 0);
                  chk("rst_count", frame_count, 0);
                  chk("rst_last", last_addr, 0);
                  chk("rst_dout", adc_dout, 0);
                  wait_n(3);
                  rst = 1'b0;
                  wait_n(h);
               end else begin
                  adc_clk = 1'b0;
                  wait_n(h);
                  cs_n    = 1'b1;
                  adc_clk = 1'b1;
                  push(EV_RISE, 0, LAT);
                  wait_n(h + 2);
               end
               return;
            end
            adc_clk = 1'b0;
            adc_din = txw[f][i];
            wait_n(h);
            adc_clk = 1'b1;
            rxw[i] = adc_dout;
            rises++;
            if (i == 0) begin
               push(EV_DONE, int'(txw[f][13:11]), LAT);
               rx_q.push_back(rxw);
               got.push_back(rxw);
            end
            if (rises == chg_at) ch_data[chg_ch*12 +: 12] = chg_val;
            wait_n(h);
         end
      end
      cs_n = 1'b1;
      push(EV_RISE, 0, LAT);
      wait_n(h + 2);
   endtask

   function automatic logic [15:0] aw(input int a);
      logic [15:0] w;
      w = '0;
      w[13:11] = a[2:0];
      return w;
   endfunction

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int nfr;
      int stop;
      int chg;
      wait_n(3);
      rst = 1'b0;
      @(posedge clk_50);
      #6;
      chk("init_dout", adc_dout, 0);
      chk("init_active", active, 0);
      chk("init_count", frame_count, 0);
      chk("init_last", last_addr, 0);

      ch_data[0 +: 12] = 12'hA5C;
      txw.delete(); txw.push_back(aw(3));
      got.delete(); p0 = pulses;
      burst(8, -1, 0, -1, 0, 12'h0);
      wait_n(4);
      chk("t1_rx", got[0], 16'h0A5C);
      chk("t1_pulses", pulses - p0, 1);
      chk("t1_last", last_addr, 3);
      chk("t1_count", frame_count, 1);

      ch_data[36 +: 12] = 12'h123;
      txw.delete(); txw.push_back(aw(5));
      got.delete();
      burst(8, -1, 0, 8, 3, 12'hEEE);
      wait_n(4);
      chk("t2_rx", got[0], 16'h0123);
      chk("t2_last", last_addr, 5);
      chk("t2_count", frame_count, 2);

      ch_data[12 +: 12] = 12'hFFF;
      ch_data[72 +: 12] = 12'h001;
      txw.delete(); txw.push_back(aw(1));
      burst(8, -1, 0, -1, 0, 12'h0);
      txw.delete(); txw.push_back(aw(6)); txw.push_back(aw(2));
      got.delete(); p0 = pulses;
      burst(8, -1, 0, -1, 0, 12'h0);
      wait_n(4);
      chk("t3_rx0", got[0], 16'h0FFF);
      chk("t3_rx1", got[1], 16'h0001);
      chk("t3_pulses", pulses - p0, 2);
      chk("t3_count", frame_count, 5);
      chk("t3_last", last_addr, 2);

      ch_data[24 +: 12] = 12'h7B4;
      txw.delete(); txw.push_back(aw(4));
      p0 = pulses;
      burst(8, 7, 0, -1, 0, 12'h0);
      txw.delete(); txw.push_back(16'hFFFF);
      burst(5, 15, 0, -1, 0, 12'h0);
      chk("t4_pulses", pulses - p0, 0);
      chk("t4_count", frame_count, 5);
      chk("t4_last", last_addr, 2);
      txw.delete(); txw.push_back(aw(7));
      got.delete();
      burst(8, -1, 0, -1, 0, 12'h0);
      wait_n(4);
      chk("t4_rx", got[0], 16'h07B4);
      chk("t4_count2", frame_count, 6);

      ch_data[0 +: 12] = 12'h3C9;
      txw.delete(); txw.push_back(aw(5));
      burst(8, 5, 1, -1, 0, 12'h0);
      txw.delete(); txw.push_back(aw(2));
      got.delete();
      burst(8, -1, 0, -1, 0, 12'h0);
      wait_n(4);
      chk("t5_rx", got[0], 16'h03C9);
      chk("t5_count", frame_count, 1);
      chk("t5_last", last_addr, 2);

      txw.delete();
      for (int i = 0; i < 15; i++) txw.push_back(16'($urandom));
      burst(4, -1, 0, -1, 0, 12'h0);
      wait_n(4);
      chk("t6_wrap", frame_count, 0);

      for (int n = 0; n < 25; n++) begin
         ch_data = {$urandom, $urandom, $urandom};
         nfr = $urandom_range(1, 3);
         txw.delete();
         for (int i = 0; i < nfr; i++) txw.push_back(16'($urandom));
         stop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16*nfr-1) : -1;
         chg  = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, 16*nfr);
         burst($urandom_range(4, 8), stop, ($urandom_range(0, 2) == 0),
               chg, $urandom_range(0, 7), 12'($urandom));
      end

      wait_n(10);
      chk("ev_drain", ev_due.size(), 0);
      chk("rx_drain", rx_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
